// File: rtl/divider_pkg.sv
// Shared widths, latency and result-bus layout for the pipelined signed divider.
package divider_pkg;

  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 24;
  localparam int PREM_W     = DIVISOR_W + 1;
  localparam int DOUT_W     = DIVIDEND_W + DIVISOR_W;
  localparam int LATENCY    = DIVIDEND_W + 2;

  localparam int QUOT_MSB = DOUT_W - 1;
  localparam int QUOT_LSB = DIVISOR_W;
  localparam int REM_MSB  = DIVISOR_W - 1;
  localparam int REM_LSB  = 0;

  function automatic logic [DOUT_W-1:0] pack_result(
    input logic [DIVIDEND_W-1:0] quot,
    input logic [DIVISOR_W-1:0]  rem
  );
    logic [DOUT_W-1:0] res;
    res                    = '0;
    res[QUOT_MSB:QUOT_LSB] = quot;
    res[REM_MSB:REM_LSB]   = rem;
    return res;
  endfunction

endpackage

// File: rtl/div_stage.sv
// One registered restoring-division iteration: shift in a dividend bit, subtract if it fits.
module div_stage
  import divider_pkg::*;
(
  input  logic                 clk,
  input  logic [PREM_W-1:0]    prem_i,
  input  logic [DIVISOR_W-1:0] dvsr_i,
  input  logic                 bit_i,
  output logic [PREM_W-1:0]    prem_o,
  output logic                 qbit_o
);

  logic [PREM_W-1:0] trial;
  logic [PREM_W-1:0] diff;
  logic [PREM_W-1:0] prem_d;
  logic              ge;

  // The incoming remainder is always below the divisor, so its top bit only
  // matters for a zero divisor, whose result is discarded downstream anyway.
  always_comb begin
    trial  = {prem_i[PREM_W-2:0], bit_i};
    diff   = trial - {1'b0, dvsr_i};
    ge     = prem_i[PREM_W-1] | (trial >= {1'b0, dvsr_i});
    prem_d = ge ? diff : trial;
  end

  always_ff @(posedge clk) begin
    prem_o <= prem_d;
    qbit_o <= ge;
  end

endmodule

// File: rtl/stream_divider.sv
// Fully pipelined signed 32/24 divider, one result per clock, AXI4-Stream style ports.
module stream_divider
  import divider_pkg::*;
(
  input  logic                  aclk,
  input  logic                  rst,
  input  logic                  s_axis_divisor_tvalid,
  output logic                  s_axis_divisor_tready,
  input  logic [DIVISOR_W-1:0]  s_axis_divisor_tdata,
  input  logic                  s_axis_dividend_tvalid,
  output logic                  s_axis_dividend_tready,
  input  logic [DIVIDEND_W-1:0] s_axis_dividend_tdata,
  output logic                  m_axis_dout_tvalid,
  output logic [DOUT_W-1:0]     m_axis_dout_tdata
);

  logic accept;

  assign s_axis_divisor_tready  = ~rst;
  assign s_axis_dividend_tready = ~rst;
  assign accept = ~rst & s_axis_divisor_tvalid & s_axis_dividend_tvalid;

  // Stage 0: operand magnitudes and result signs
  logic [DIVIDEND_W-1:0] dvnd_mag_d;
  logic [DIVISOR_W-1:0]  dvsr_mag_d;

  always_comb begin
    dvnd_mag_d = s_axis_dividend_tdata[DIVIDEND_W-1] ? -s_axis_dividend_tdata
                                                     :  s_axis_dividend_tdata;
    dvsr_mag_d = s_axis_divisor_tdata[DIVISOR_W-1] ? -s_axis_divisor_tdata
                                                   :  s_axis_divisor_tdata;
  end

  logic [DIVIDEND_W-1:0] dvnd_q [0:DIVIDEND_W-1];
  logic [DIVISOR_W-1:0]  dvsr_q [0:DIVIDEND_W-1];
  logic                  qneg_q [0:DIVIDEND_W];
  logic                  rneg_q [0:DIVIDEND_W];
  logic                  zero_q [0:DIVIDEND_W];
  logic [PREM_W-1:0]     prem_w [0:DIVIDEND_W];
  logic                  qbit_w [1:DIVIDEND_W];
  logic [DIVIDEND_W-2:0] qacc_q [2:DIVIDEND_W];

  always_ff @(posedge aclk) begin
    dvnd_q[0] <= dvnd_mag_d;
    dvsr_q[0] <= dvsr_mag_d;
    qneg_q[0] <= s_axis_dividend_tdata[DIVIDEND_W-1] ^ s_axis_divisor_tdata[DIVISOR_W-1];
    rneg_q[0] <= s_axis_dividend_tdata[DIVIDEND_W-1];
    zero_q[0] <= (s_axis_divisor_tdata == '0);
  end

  assign prem_w[0] = '0;

  generate
    for (genvar gi = 0; gi < DIVIDEND_W; gi++) begin : g_stage
      div_stage u_stage (
        .clk    (aclk),
        .prem_i (prem_w[gi]),
        .dvsr_i (dvsr_q[gi]),
        .bit_i  (dvnd_q[gi][DIVIDEND_W-1-gi]),
        .prem_o (prem_w[gi+1]),
        .qbit_o (qbit_w[gi+1])
      );

      always_ff @(posedge aclk) begin
        qneg_q[gi+1] <= qneg_q[gi];
        rneg_q[gi+1] <= rneg_q[gi];
        zero_q[gi+1] <= zero_q[gi];
      end

      if (gi < DIVIDEND_W - 1) begin : g_operands
        always_ff @(posedge aclk) begin
          dvnd_q[gi+1] <= dvnd_q[gi];
          dvsr_q[gi+1] <= dvsr_q[gi];
        end
      end

      // Quotient bits arrive MSB first and are collected one stage behind.
      if (gi == 1) begin : g_qacc_first
        always_ff @(posedge aclk) begin
          qacc_q[2] <= {{(DIVIDEND_W-2){1'b0}}, qbit_w[1]};
        end
      end else if (gi >= 2) begin : g_qacc
        always_ff @(posedge aclk) begin
          qacc_q[gi+1] <= {qacc_q[gi][DIVIDEND_W-3:0], qbit_w[gi]};
        end
      end
    end
  endgenerate

  // Final stage: apply signs; -2^31 / -1 wraps back to -2^31 naturally.
  logic [DIVIDEND_W-1:0] q_mag;
  logic [DIVISOR_W-1:0]  r_mag;
  logic [DOUT_W-1:0]     res_d;
  logic [DOUT_W-1:0]     res_q;

  always_comb begin
    q_mag = {qacc_q[DIVIDEND_W], qbit_w[DIVIDEND_W]};
    r_mag = prem_w[DIVIDEND_W][DIVISOR_W-1:0];
    res_d = pack_result(qneg_q[DIVIDEND_W] ? -q_mag : q_mag,
                        rneg_q[DIVIDEND_W] ? -r_mag : r_mag);
    if (zero_q[DIVIDEND_W]) begin
      res_d = '0;
    end
  end

  always_ff @(posedge aclk) begin
    res_q <= res_d;
  end

  // The output register loads only on valid so tdata holds between results;
  // the valid chain therefore runs one flop past the data pipeline.
  logic [LATENCY-1:0] vld_q;
  logic               tvalid_q;
  logic [DOUT_W-1:0]  tdata_q;

  always_ff @(posedge aclk) begin
    if (rst) begin
      vld_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      vld_q    <= {vld_q[LATENCY-2:0], accept};
      tvalid_q <= vld_q[LATENCY-1];
      if (vld_q[LATENCY-1]) begin
        tdata_q <= res_q;
      end
    end
  end

  assign m_axis_dout_tvalid = tvalid_q;
  assign m_axis_dout_tdata  = tdata_q;

endmodule

// File: tb/tb_stream_divider.sv
// Self-checking bench for stream_divider: directed, back-to-back, random and reset scenarios.
`timescale 1ns/1ps
module tb_stream_divider;

  localparam int LAT = 34;
  localparam int NDIR = 11;

  logic        aclk = 1'b0;
  logic        rst = 1'b1;
  logic        s_axis_divisor_tvalid = 1'b0;
  logic        s_axis_divisor_tready;
  logic [23:0] s_axis_divisor_tdata = '0;
  logic        s_axis_dividend_tvalid = 1'b0;
  logic        s_axis_dividend_tready;
  logic [31:0] s_axis_dividend_tdata = '0;
  logic        m_axis_dout_tvalid;
  logic [55:0] m_axis_dout_tdata;

  int checks = 0;
  int failures = 0;

  stream_divider dut (
    .aclk                   (aclk),
    .rst                    (rst),
    .s_axis_divisor_tvalid  (s_axis_divisor_tvalid),
    .s_axis_divisor_tready  (s_axis_divisor_tready),
    .s_axis_divisor_tdata   (s_axis_divisor_tdata),
    .s_axis_dividend_tvalid (s_axis_dividend_tvalid),
    .s_axis_dividend_tready (s_axis_dividend_tready),
    .s_axis_dividend_tdata  (s_axis_dividend_tdata),
    .m_axis_dout_tvalid     (m_axis_dout_tvalid),
    .m_axis_dout_tdata      (m_axis_dout_tdata)
  );

  always #5 aclk = ~aclk;

  // Reference: plain truncating integer division on 64-bit values.
  function automatic logic [55:0] ref_div(input logic signed [31:0] dd, input logic signed [23:0] dv);
    longint a;
    longint b;
    longint q;
    longint r;
    logic [31:0] q32;
    logic [23:0] r24;
    if (dv == 0) return '0;
    a = dd;
    b = dv;
    q = a / b;
    r = a - q * b;
    q32 = q[31:0];
    r24 = r[23:0];
    return {q32, r24};
  endfunction

  typedef struct {
    int          due;
    logic [55:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          edge_cnt = 0;
  logic        exp_v = 1'b0;
  logic [55:0] exp_d = '0;

  // Scoreboard: every accept is due LAT edges later; reset drops everything in flight.
  always @(posedge aclk) begin
    edge_cnt <= edge_cnt + 1;
    if (rst) begin
      exp_q.delete();
      exp_v <= 1'b0;
      exp_d <= '0;
    end else begin
      if (s_axis_divisor_tvalid && s_axis_dividend_tvalid)
        exp_q.push_back('{due: edge_cnt + LAT,
                          data: ref_div(s_axis_dividend_tdata, s_axis_divisor_tdata)});
      if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
        exp_v <= 1'b1;
        exp_d <= exp_q[0].data;
        void'(exp_q.pop_front());
      end else begin
        exp_v <= 1'b0;
      end
    end
  end

  int dd_t [NDIR] = '{49999890, 50000000, 50000000, -49999890, 7, 0, 12345,
                      -2147483647 - 1, -2147483647 - 1, 2147483647, -2147483647 - 1};
  int dv_t [NDIR] = '{100000, 150000, 100000, 100000, -2, -5, 0,
                      -1, 1, -8388608, -8388608};
  int q_t  [NDIR] = '{499, 333, 500, -499, -3, 0, 0,
                      -2147483647 - 1, -2147483647 - 1, -255, 256};
  int r_t  [NDIR] = '{99890, 50000, 0, -99890, 1, 0, 0, 0, 0, 8388607, 0};

  task automatic drive(input logic vd, input logic [31:0] dd, input logic vs, input logic [23:0] dv);
    s_axis_dividend_tvalid = vd;
    s_axis_dividend_tdata  = dd;
    s_axis_divisor_tvalid  = vs;
    s_axis_divisor_tdata   = dv;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0);
    repeat (3) tick();
    checks++;
    if (m_axis_dout_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_tvalid got=%b exp=0", m_axis_dout_tvalid);
    end
    checks++;
    if (m_axis_dout_tdata !== 56'd0) begin
      failures++;
      $display("FAIL reset_tdata got=%h exp=0", m_axis_dout_tdata);
    end
    checks++;
    if ({s_axis_dividend_tready, s_axis_divisor_tready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_tready got=%b exp=00", {s_axis_dividend_tready, s_axis_divisor_tready});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({s_axis_dividend_tready, s_axis_divisor_tready} !== 2'b11) begin
      failures++;
      $display("FAIL release_tready got=%b exp=11", {s_axis_dividend_tready, s_axis_divisor_tready});
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_directed();
    int e;
    int e0 = 0;
    int k = 0;
    logic [55:0] want;
    for (int c = 0; c < NDIR + LAT + 4; c++) begin
      if (c < NDIR) drive(1'b1, 32'(dd_t[c]), 1'b1, 24'(dv_t[c]));
      else          drive(1'b0, '0, 1'b0, '0);
      tick();
      e = edge_cnt - 1;
      if (c == 0) e0 = e;
      checks++;
      if (m_axis_dout_tvalid !== exp_v) begin
        failures++;
        $display("FAIL dir_tvalid edge=%0d got=%b exp=%b", e, m_axis_dout_tvalid, exp_v);
      end
      if (m_axis_dout_tvalid === 1'b1 && k < NDIR) begin
        want = {32'(q_t[k]), 24'(r_t[k])};
        checks++;
        if (m_axis_dout_tdata !== want) begin
          failures++;
          $display("FAIL dir_result idx=%0d dd=%0d dv=%0d got=%h exp=%h",
                   k, dd_t[k], dv_t[k], m_axis_dout_tdata, want);
        end
        if (k == 0) begin
          checks++;
          if (e !== e0 + LAT) begin
            failures++;
            $display("FAIL dir_latency got_edge=%0d exp_edge=%0d", e, e0 + LAT);
          end
        end
        $display("directed idx=%0d dd=%0d dv=%0d dout=%h", k, dd_t[k], dv_t[k], m_axis_dout_tdata);
        k++;
      end
    end
    checks++;
    if (k !== NDIR) begin
      failures++;
      $display("FAIL dir_count got=%0d exp=%0d", k, NDIR);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    int n_acc = 0;
    int n_out = 0;
    logic vs;
    logic vd;
    for (int c = 0; c < 40 + LAT + 3; c++) begin
      if (c < 40) begin
        vs = (c % 7) != 3;
        vd = (c % 11) != 5;
        if (vs && vd) n_acc++;
        drive(vd, 32'(c), vs, 24'd3);
      end else begin
        drive(1'b0, '0, 1'b0, '0);
      end
      tick();
      e = edge_cnt - 1;
      checks++;
      if (m_axis_dout_tvalid !== exp_v) begin
        failures++;
        $display("FAIL b2b_tvalid edge=%0d got=%b exp=%b", e, m_axis_dout_tvalid, exp_v);
      end
      checks++;
      if (m_axis_dout_tdata !== exp_d) begin
        failures++;
        $display("FAIL b2b_tdata edge=%0d got=%h exp=%h", e, m_axis_dout_tdata, exp_d);
      end
      if (m_axis_dout_tvalid === 1'b1) begin
        n_out++;
        $display("b2b edge=%0d dout=%h", e, m_axis_dout_tdata);
      end
    end
    checks++;
    if (n_out !== n_acc) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=%0d", n_out, n_acc);
    end
  endtask

  task automatic test_random();
    int e;
    logic [31:0] dd;
    logic [23:0] dv;
    for (int c = 0; c < 300 + LAT + 3; c++) begin
      if (c < 300) begin
        case ($urandom_range(0, 9))
          0:       dd = 32'h8000_0000;
          1:       dd = '0;
          2:       dd = 32'h7fff_ffff;
          default: dd = $urandom();
        endcase
        case ($urandom_range(0, 9))
          0:       dv = '0;
          1:       dv = 24'hff_ffff;
          2:       dv = 24'($urandom_range(1, 20));
          3:       dv = 24'h80_0000;
          default: dv = 24'($urandom());
        endcase
        drive($urandom_range(0, 9) < 8, dd, $urandom_range(0, 9) < 8, dv);
      end else begin
        drive(1'b0, '0, 1'b0, '0);
      end
      tick();
      e = edge_cnt - 1;
      checks++;
      if (m_axis_dout_tvalid !== exp_v) begin
        failures++;
        $display("FAIL rand_tvalid edge=%0d got=%b exp=%b", e, m_axis_dout_tvalid, exp_v);
      end
      checks++;
      if (m_axis_dout_tdata !== exp_d) begin
        failures++;
        $display("FAIL rand_tdata edge=%0d got=%h exp=%h", e, m_axis_dout_tdata, exp_d);
      end
      if (m_axis_dout_tvalid === 1'b1)
        $display("rand edge=%0d dout=%h", e, m_axis_dout_tdata);
    end
  endtask

  task automatic test_mid_reset();
    int e;
    int e_first = -1;
    int e_out = -1;
    for (int c = 0; c < 14 + LAT + 4; c++) begin
      rst = (c == 10);
      if (c >= 11 && c <= 13) drive(1'b0, '0, 1'b0, '0);
      else drive(1'b1, $urandom(), 1'b1, 24'($urandom_range(1, 1000)));
      if (c == 10) begin
        #1;
        checks++;
        if ({s_axis_dividend_tready, s_axis_divisor_tready} !== 2'b00) begin
          failures++;
          $display("FAIL midrst_tready got=%b exp=00", {s_axis_dividend_tready, s_axis_divisor_tready});
        end
      end
      tick();
      e = edge_cnt - 1;
      if (c == 14) e_first = e;
      checks++;
      if (m_axis_dout_tvalid !== exp_v) begin
        failures++;
        $display("FAIL midrst_tvalid edge=%0d got=%b exp=%b", e, m_axis_dout_tvalid, exp_v);
      end
      checks++;
      if (m_axis_dout_tdata !== exp_d) begin
        failures++;
        $display("FAIL midrst_tdata edge=%0d got=%h exp=%h", e, m_axis_dout_tdata, exp_d);
      end
      if (m_axis_dout_tvalid === 1'b1 && e_out < 0) begin
        e_out = e;
        $display("midrst first_out edge=%0d dout=%h", e, m_axis_dout_tdata);
      end
    end
    rst = 1'b0;
    checks++;
    if (e_out !== e_first + LAT) begin
      failures++;
      $display("FAIL midrst_first_valid got_edge=%0d exp_edge=%0d", e_out, e_first + LAT);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
